vga_elevator_display: RTL
=========================

// Module: vga_elevator_display
// PURPOSE
//  Parametrised successor to the two-car VGA elevator view.
//  Generates VGA timing and draws N_ELEV shafts, each with an animated car.
//  Each car glides toward its commanded floor at STEP_PX pixels per frame.
//  Adds per-car arrival flags, a blinking STOP indication and a frozen MAINT mode.
//  Sits between the elevator controller (destination, sim_state) and the board DAC pins.
// PARAMETERS
//  N_ELEV       2    number of shafts/cars drawn
//  FLOOR_W      4    bits per car in destination
//  N_FLOORS     7    floors 0..N_FLOORS-1
//  FLOOR_PX     60   vertical pixels per floor
//  STEP_PX      4    car motion per frame in RUN
//  BLINK_FRAMES 30   frames per STOP blink half-period
//  H_ACTIVE/H_FP/H_SYNC/H_BP  640/16/96/48   horizontal timing, pixels
//  V_ACTIVE/V_FP/V_SYNC/V_BP  480/10/2/33    vertical timing, lines
//  SYNC_POL     0    sync active level; 0 = active-low
// PORTS
//  pixel_clk    in   1              pixel clock, 25 MHz nominal; the single clock
//  reset        in   1              asynchronous, active-low reset (0 = reset)
//  destination  in   N_ELEV*FLOOR_W car i commanded floor = [i*FLOOR_W +: FLOOR_W]
//  sim_state    in   2              00 IDLE, 01 RUN, 10 STOP, 11 MAINT
//  hsync        out  1              horizontal sync
//  vsync        out  1              vertical sync
//  horiz_count  out  10             pixel x, aligned with R/G/B
//  vert_count   out  10             pixel y, aligned with R/G/B
//  R, G, B      out  4 each         pixel colour, 0 outside the active area
//  frame_start  out  1              one-cycle pulse when x=0, y=0 is presented
//  arrived      out  N_ELEV         bit i = car i position equals its latched target
// BEHAVIOUR
//  Reset values:
//  - counters 0, RGB 0, frame_start 0
//  - hsync and vsync at the inactive level (~SYNC_POL)
//  - all car positions 0, latched targets 0, arrived all-ones
//  Timing:
//  - h counts 0..H_TOTAL-1 and wraps; v advances when h wraps and counts 0..V_TOTAL-1.
//  - hsync is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync uses the same rule on v.
//  - All outputs are registered once. Sync, counts, RGB and frame_start leave the block mutually aligned.
//  Frame update, on each internal (h=0, v=0) cycle:
//  - latch every destination into its target. No mid-frame tearing; changes within a frame are ignored.
//  - floor values >= N_FLOORS clamp to N_FLOORS-1. target_px = floor*FLOOR_PX.
//  - RUN: pos moves toward target_px by min(STEP_PX, |diff|). It never overshoots, and reversal is immediate.
//  - IDLE/STOP/MAINT: pos holds; the target is still latched.
//  - the blink counter advances every frame and toggles the blink phase at BLINK_FRAMES.
//  - the blink counter resets to phase-on on any entry into STOP.
//  arrived: combinational compare of registered pos and target; updates the cycle after the frame update.
//  Drawing, active area only:
//  - column i spans x in [i*H_ACTIVE/N_ELEV, (i+1)*H_ACTIVE/N_ELEV).
//  - 2-px white (FFF) shaft border on the column edges.
//  - car occupies y in [V_ACTIVE-pos-FLOOR_PX+2, V_ACTIVE-pos-2) and is inset 8 px from the column edges.
//  - car colour: RUN moving = 0F0, RUN arrived = 00F, IDLE = FF0,
//    STOP = F00 in blink phase-on and 000 in phase-off, MAINT = 888.
//  - background 000.
//  Boundaries and mid-operation events:
//  - a sim_state change mid-frame affects colour immediately and motion from the next frame update.
//  - reset asserted mid-frame forces all reset values asynchronously.
//  - after reset release, the first frame_start comes 1 cycle later.
// STRUCTURE
//  Package vga_pkg:
//  - timing localparams and H_TOTAL/V_TOTAL
//  - sim_state_t enum (IDLE, RUN, STOP, MAINT)
//  - 12-bit colour constants
//  Sub-module vga_timing: h/v counters, sync generation, active flag, frame_start. Parametrised by the timing set.
//  Top level: per-car position and target registers (generate loop), blink counter, pixel shader, output register.
// TESTING
//  1. Reset, then release -> first frame_start 1 cycle later;
//     hsync period 800 clks and low for 96 clks; vsync period 420000 clks and low for 1600 clks.
//  2. RUN, car0 dest 0->1 -> pos reaches 60 after 15 frames; arrived[0] is 0 during the move and 1 after.
//     Car colour is 0F0 while moving and 00F once arrived.
//  3. RUN, car1 dest 9 (>N_FLOORS-1) -> clamps; pos settles at 360; arrived[1]=1.
//  4. Car0 moving up, dest changed to 0 mid-frame -> no change until the next frame_start, then pos decreases by 4 per frame.
//  5. STOP while moving -> pos frozen; car shows F00 for 30 frames, then 000 for 30, repeating.
//     Returning to RUN resumes motion.
//  6. reset low mid-frame at x=300 -> next cycle: RGB 0, syncs inactive, pos 0, arrived all-ones.
//     Parameter sweep N_ELEV=4: column width 160; test 2 repeats for car 3.

Source files
------------

// File: rtl/vga_elevator_display_pkg.sv
// Shared raster defaults, controller state encoding and 12-bit palette
// for the elevator VGA view.
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int CNT_W        = 10;
  localparam int BORDER_PX    = 2;
  localparam int CAR_INSET_PX = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STOP  = 2'b10,
    ST_MAINT = 2'b11
  } sim_state_t;

  localparam logic [11:0] COL_BLACK  = 12'h000;
  localparam logic [11:0] COL_WHITE  = 12'hFFF;
  localparam logic [11:0] COL_GREEN  = 12'h0F0;
  localparam logic [11:0] COL_BLUE   = 12'h00F;
  localparam logic [11:0] COL_YELLOW = 12'hFF0;
  localparam logic [11:0] COL_RED    = 12'hF00;
  localparam logic [11:0] COL_GREY   = 12'h888;

  function automatic int span_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_elevator_display_timing.sv
// Free-running raster counters with sync, active-area and frame-origin decode.
// Everything here is combinational off the counters; the top registers it.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             pixel_clk_i,
  input  logic             rst_n_i,
  output logic [CNT_W-1:0] h_o,
  output logic [CNT_W-1:0] v_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             active_o,
  output logic             frame_tick_o
);
  localparam int HT = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge pixel_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o          = h_q;
  assign v_o          = v_q;
  assign hsync_o      = (h_q >= HS_BEG && h_q < HS_END) ? SYNC_POL : ~SYNC_POL;
  assign vsync_o      = (v_q >= VS_BEG && v_q < VS_END) ? SYNC_POL : ~SYNC_POL;
  assign active_o     = (h_q < H_ACT) && (v_q < V_ACT);
  assign frame_tick_o = (h_q == '0) && (v_q == '0);
endmodule

// File: rtl/vga_elevator_display.sv
// Elevator shaft view: per-car glide toward the commanded floor, STOP blink,
// pixel shader and a single output register stage aligning sync/counts/RGB.
module vga_elevator_display
  import vga_pkg::*;
#(
  parameter int N_ELEV       = 2,
  parameter int FLOOR_W      = 4,
  parameter int N_FLOORS     = 7,
  parameter int FLOOR_PX     = 60,
  parameter int STEP_PX      = 4,
  parameter int BLINK_FRAMES = 30,
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int H_FP         = H_FP_DEF,
  parameter int H_SYNC       = H_SYNC_DEF,
  parameter int H_BP         = H_BP_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int V_FP         = V_FP_DEF,
  parameter int V_SYNC       = V_SYNC_DEF,
  parameter int V_BP         = V_BP_DEF,
  parameter bit SYNC_POL     = 1'b0
) (
  input  logic                      pixel_clk,
  input  logic                      reset,
  input  logic [N_ELEV*FLOOR_W-1:0] destination,
  input  logic [1:0]                sim_state,
  output logic                      hsync,
  output logic                      vsync,
  output logic [CNT_W-1:0]          horiz_count,
  output logic [CNT_W-1:0]          vert_count,
  output logic [3:0]                R,
  output logic [3:0]                G,
  output logic [3:0]                B,
  output logic                      frame_start,
  output logic [N_ELEV-1:0]         arrived
);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] STEP     = CNT_W'(STEP_PX);

  sim_state_t state;
  assign state = sim_state_t'(sim_state);

  logic [CNT_W-1:0] h, v;
  logic             hsync_c, vsync_c, active, frame_tick;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL)
  ) u_timing (
    .pixel_clk_i (pixel_clk),
    .rst_n_i     (reset),
    .h_o         (h),
    .v_o         (v),
    .hsync_o     (hsync_c),
    .vsync_o     (vsync_c),
    .active_o    (active),
    .frame_tick_o(frame_tick)
  );

  logic [N_ELEV-1:0][CNT_W-1:0] pos_q, pos_d, tgt_q, tgt_d;
  logic [N_ELEV-1:0]            car_hit, border_hit;
  logic [BLK_W-1:0]             blink_cnt_q;
  logic                         blink_on_q, stop_q, blink_on;
  logic [11:0]                  pix_d;

  function automatic logic [CNT_W-1:0] floor_to_px(input logic [FLOOR_W-1:0] fl);
    int f;
    f = (int'(fl) >= N_FLOORS) ? N_FLOORS - 1 : int'(fl);
    return CNT_W'(f * FLOOR_PX);
  endfunction

  function automatic logic [11:0] car_colour(input sim_state_t st, input logic arr,
                                             input logic on);
    logic [11:0] c;
    case (st)
      ST_RUN:  c = arr ? COL_BLUE : COL_GREEN;
      ST_IDLE: c = COL_YELLOW;
      ST_STOP: c = on ? COL_RED : COL_BLACK;
      default: c = COL_GREY;
    endcase
    return c;
  endfunction

  for (genvar i = 0; i < N_ELEV; i++) begin : g_car
    localparam int X0 = i * H_ACTIVE / N_ELEV;
    localparam int X1 = (i + 1) * H_ACTIVE / N_ELEV;
    logic [CNT_W-1:0] cur, tgt;

    assign cur      = pos_q[i];
    assign tgt      = floor_to_px(destination[i*FLOOR_W +: FLOOR_W]);
    assign tgt_d[i] = tgt;
    // Motion uses the freshly latched target, so a reversal takes effect on this update.
    assign pos_d[i] = (state != ST_RUN) ? cur
                    : (cur < tgt) ? ((tgt - cur > STEP) ? cur + STEP : tgt)
                    : ((cur - tgt > STEP) ? cur - STEP : tgt);
    assign arrived[i] = (pos_q[i] == tgt_q[i]);

    assign border_hit[i] = (int'(h) >= X0 && int'(h) < X0 + BORDER_PX) ||
                           (int'(h) >= X1 - BORDER_PX && int'(h) < X1);
    // Row window written additively to stay unsigned near the top of the shaft.
    assign car_hit[i] = (int'(h) >= X0 + CAR_INSET_PX) && (int'(h) < X1 - CAR_INSET_PX) &&
                        (int'(v) + int'(cur) + FLOOR_PX >= V_ACTIVE + 2) &&
                        (int'(v) + int'(cur) + 2 < V_ACTIVE);
  end

  // The entry cycle itself must already show phase-on, before the counter reloads.
  assign blink_on = blink_on_q || (state == ST_STOP && !stop_q);

  always_comb begin
    pix_d = COL_BLACK;
    if (active) begin
      for (int i = 0; i < N_ELEV; i++) begin
        if (car_hit[i])    pix_d = car_colour(state, arrived[i], blink_on);
        if (border_hit[i]) pix_d = COL_WHITE;
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      pos_q       <= '0;
      tgt_q       <= '0;
      stop_q      <= 1'b0;
      blink_on_q  <= 1'b1;
      blink_cnt_q <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      horiz_count <= '0;
      vert_count  <= '0;
      {R, G, B}   <= '0;
      frame_start <= 1'b0;
    end else begin
      stop_q <= (state == ST_STOP);
      if (frame_tick) begin
        pos_q <= pos_d;
        tgt_q <= tgt_d;
      end
      if (state == ST_STOP && !stop_q) begin
        blink_cnt_q <= '0;
        blink_on_q  <= 1'b1;
      end else if (frame_tick) begin
        if (blink_cnt_q == BLK_LAST) begin
          blink_cnt_q <= '0;
          blink_on_q  <= ~blink_on_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
      hsync       <= hsync_c;
      vsync       <= vsync_c;
      horiz_count <= h;
      vert_count  <= v;
      {R, G, B}   <= pix_d;
      frame_start <= frame_tick;
    end
  end
endmodule
